// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum UART transmitter.
// SUM_UART_PARITY_EN: when defined, frames carry an even-parity bit (8E1).
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef SUM_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/sum_uart_fifo.sv
// Small synchronous FIFO buffering sum bytes ahead of the serialiser.
// Pushes while full and pops while empty are ignored; head data is
// presented combinationally on pop_data.
module sum_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next-state for storage, pointers (wrap naturally) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sum_uart_tx.sv
// Sum-byte UART transmitter: valid/ready input into a FIFO, then 8N1
// serialisation (8E1 when SUM_UART_PARITY_EN is defined) on tx.
//
// Handshake: a byte transfers on any rising edge where in_valid && in_ready.
// in_ready depends only on registered FIFO occupancy; in_valid while
// in_ready is low never transfers and sets the sticky overflow flag.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
`ifdef SUM_UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 bit_end;

  sum_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);
  assign bit_end  = (baud_q == '0);

  // Frame sequencer: next state, baud count, shifter, pop and next tx level.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (in_valid & fifo_full);
`ifdef SUM_UART_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_data;
          baud_d    = BAUD_LOAD;
          bit_idx_d = '0;
          state_d   = START;
`ifdef SUM_UART_PARITY_EN
          parity_d  = ^fifo_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`ifdef SUM_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = BAUD_LOAD;
          state_d = STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle bit.
            fifo_pop  = 1'b1;
            shift_d   = fifo_data;
            baud_d    = BAUD_LOAD;
            bit_idx_d = '0;
            state_d   = START;
`ifdef SUM_UART_PARITY_EN
            parity_d  = ^fifo_data;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the level the next state will drive.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef SUM_UART_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef SUM_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef SUM_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_sum_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  sum_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks tx for one whole frame of byte b, starting at cycle 'skip' of the
  // frame (cycle 0 is the first start-bit cycle). Optionally offers byte pd
  // on the edge that ends cycle poke_k. Leaves the bench just after the last
  // edge of the frame.
  task automatic expect_frame(input logic [7:0] b, input int skip,
                              input bit poke, input int poke_k, input logic [7:0] pd);
    logic [10:0] fr;
    int          nb;
`ifdef SUM_UART_PARITY_EN
    fr = {1'b1, ^b, b, 1'b0};
    nb = 11;
`else
    fr = {2'b11, b, 1'b0};
    nb = 10;
`endif
    for (int k = skip; k < nb * CPB; k++) begin
      check($sformatf("tx_%02h_k%0d", b, k), {31'd0, tx}, {31'd0, fr[k / CPB]});
      if (poke && k == poke_k) begin
        in_valid = 1'b1;
        in_data  = pd;
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",       {31'd0, tx},       32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5: start at E+1, busy drops at E+41.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("a5_busy_after_push", {31'd0, busy}, 32'd1);
    check("a5_tx_still_idle",   {31'd0, tx},   32'd1);
    tick();
    expect_frame(8'hA5, 0, 1'b0, 0, 8'h00);
`ifndef SUM_UART_PARITY_EN
    check("a5_busy_at_e41", {31'd0, busy}, 32'd0);
`else
    check("a5_busy_at_e45", {31'd0, busy}, 32'd0);
`endif

    // 0xEE in flight, then 0x01..0x04 fill the FIFO; 0x05 is rejected.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    in_data = 8'h01;
    tick();
    check("ee_start_low", {31'd0, tx}, 32'd0);
    in_data = 8'h02;
    tick();
    in_data = 8'h03;
    tick();
    in_data = 8'h04;
    tick();
    check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    check("overflow_set",       {31'd0, overflow}, 32'd1);
    check("in_ready_still_low", {31'd0, in_ready}, 32'd0);
    // STOP-end pop coincides with an offer of 0x55 while full: no push.
    expect_frame(8'hEE, 4, 1'b1, 39, 8'h55);
    check("in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    expect_frame(8'h01, 0, 1'b0, 0, 8'h00);
    expect_frame(8'h02, 0, 1'b0, 0, 8'h00);
    expect_frame(8'h03, 0, 1'b0, 0, 8'h00);
    expect_frame(8'h04, 0, 1'b0, 0, 8'h00);
    check("burst_busy_done",   {31'd0, busy},     32'd0);
    check("overflow_sticky",   {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("no_05_tx_%0d", i), {31'd0, tx}, 32'd1);
      tick();
    end
    check("no_05_busy", {31'd0, busy}, 32'd0);

    // Stream 0x10..0x19, one byte offered mid-frame, exercising wrap.
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      expect_frame(8'(16 + i), 0, (i < 9), 20, 8'(17 + i));
    end
    check("stream_busy_done", {31'd0, busy}, 32'd0);

    // Reset at cycle 15 of a 0xFF frame with 0x81 still queued.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    check("ff_busy_before_rst",     {31'd0, busy},     32'd1);
    check("overflow_before_rst",    {31'd0, overflow}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx",       {31'd0, tx},       32'd1);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    check("midrst_busy",     {31'd0, busy},     32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("post_rst_tx_%0d", i), {31'd0, tx}, 32'd1);
      tick();
    end
    check("post_rst_busy_empty", {31'd0, busy}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    expect_frame(8'h3C, 0, 1'b0, 0, 8'h00);
    check("3c_busy_done", {31'd0, busy}, 32'd0);

    // 0x07: three ones, parity bit 1 when parity frames are built.
    in_valid = 1'b1;
    in_data  = 8'h07;
    tick();
    in_valid = 1'b0;
    tick();
    expect_frame(8'h07, 0, 1'b0, 0, 8'h00);
    check("07_busy_done", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
Downstream stage of the 8-bit sum datapath. Accepts sum bytes over a valid/ready handshake and buffers them in a small FIFO. Serialises each byte as an 8N1 UART frame on a single output pin, so the sum stream can be logged off-chip through one uo_out bit.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (>= 2); 87 gives 115200 baud at 10 MHz
FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  sum byte to transmit
in_valid  input  1  in_data valid this cycle
in_ready  output  1  FIFO can accept a byte this cycle
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress or FIFO non-empty
overflow  output  1  sticky: in_valid seen while in_ready low

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: tx=1, in_ready=1, busy=0, overflow=0, FIFO empty, FSM IDLE, all counters 0.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronous).
  - FIFO contents are discarded.
  - No partial frame resumes after reset release.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = !full, computed from the registered count only.
  - When full, no push occurs even if a pop happens on the same edge.
- Overflow: set on any edge with in_valid && !in_ready. Stays set until reset. Never drops data already queued.
- FIFO:
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift_reg[0], LSB first, CLKS_PER_BIT cycles per bit. Shift right at each bit end. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Latency:
  - A byte accepted at edge E into an empty, idle block drives tx low at edge E+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- tx is a registered output, so it is glitch-free.
- busy = (state != IDLE) || (count != 0), registered or combinational from registers.
- Baud counter: counts down to 0, reloads at every bit boundary, and is never free-running in IDLE.

Optional Feature:
SUM_UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11*CLKS_PER_BIT cycles.
- Undefined: 8N1, no PARITY state, and no parity logic synthesised.

Decomposition:
- Package sum_uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - FRAME_BITS, which is 10, or 11 under the macro.
- One natural sub-module: sum_uart_fifo.
  - A synchronous FIFO parameterised by DEPTH and WIDTH=8.
  - Push/pop ports plus full, empty and count.
  - The top holds the FSM, baud counter and shift register.

Test Plan:
- CLKS_PER_BIT=4, push 0xA5 at edge E.
  - tx low at E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles.
  - busy falls at E+41.
- Push 0x01,0x02,0x03,0x04 back-to-back, then 0x05 with in_valid held.
  - in_ready low after the 4th push; overflow=1; 0x05 is never transmitted.
  - Four frames are sent with no idle gap between stops and starts.
- With the FIFO full, the STOP end pops while in_valid=1 on the same edge.
  - No push that edge; in_ready rises the next cycle; count goes 4->3.
- Stream 10 bytes 0x10..0x19 at one byte per frame time to exercise pointer wrap.
  - The serial output decodes to exactly 0x10..0x19 in order.
- Assert rst_n low at cycle 15 of a frame carrying 0xFF.
  - tx=1 and overflow=0 immediately; FIFO empty after release.
  - A new push of 0x3C transmits a clean frame.
- With SUM_UART_PARITY_EN, push 0x07 (three ones).
  - Parity bit = 1; frame is 11*CLKS_PER_BIT cycles.
